// File: rtl/attn_seq_pkg.sv
// attn_seq_pkg: FSM states, phases and SRAM header layout for attn_phase_sequencer (ATTN_SCORE_PHASE_EN makes S the last phase)
package attn_seq_pkg;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FETCH      = 3'd1;
  localparam logic [2:0] ST_FETCH_WAIT = 3'd2;
  localparam logic [2:0] ST_CALC       = 3'd3;
  localparam logic [2:0] ST_START      = 3'd4;
  localparam logic [2:0] ST_ACK        = 3'd5;
  localparam logic [2:0] ST_DONE       = 3'd6;
  typedef enum logic [1:0] {PH_Q, PH_K, PH_V, PH_S} phase_t;
  localparam logic SRC_IN_W    = 1'b0;
  localparam logic SRC_RES_RES = 1'b1;
  localparam int HDR_ROWS_LSB  = 16;
  localparam int HDR_INNER_LSB = 0;
  localparam int HDR_COLS_LSB  = 0;
`ifdef ATTN_SCORE_PHASE_EN
  localparam phase_t PH_LAST = PH_S;
`else
  localparam phase_t PH_LAST = PH_V;
`endif
endpackage

// File: rtl/phase_addr_gen.sv
// phase_addr_gen: maps a phase to MAC bases, dims and source select (phase S only with ATTN_SCORE_PHASE_EN)
module phase_addr_gen
  import attn_seq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 16
) (
  input  phase_t            i_phase,
  input  logic [ADDR_W-1:0] i_wsz,
  input  logic [ADDR_W-1:0] i_rsz,
  input  logic [DIM_W-1:0]  i_rows,
  input  logic [DIM_W-1:0]  i_inner,
  input  logic [DIM_W-1:0]  i_cols,
  output logic              o_src_sel,
  output logic [ADDR_W-1:0] o_opa_base,
  output logic [ADDR_W-1:0] o_opb_base,
  output logic [ADDR_W-1:0] o_result_base,
  output logic [DIM_W-1:0]  o_rows,
  output logic [DIM_W-1:0]  o_inner,
  output logic [DIM_W-1:0]  o_cols
);
  logic              w_s;
  logic [ADDR_W-1:0] w_woff;
  logic [ADDR_W-1:0] w_roff;
`ifdef ATTN_SCORE_PHASE_EN
  assign w_s = i_phase == PH_S;
`else
  assign w_s = 1'b0;
`endif
  assign w_woff        = i_phase == PH_K ? i_wsz : i_phase == PH_V ? i_wsz << 1 : '0;
  assign w_roff        = i_phase == PH_K ? i_rsz : i_phase == PH_V ? i_rsz << 1 : '0;
  // weight word 0 is the header, so weight matrices start at address 1
  assign o_src_sel     = w_s ? SRC_RES_RES : SRC_IN_W;
  assign o_opa_base    = w_s ? '0 : ADDR_W'(1);
  assign o_opb_base    = w_s ? i_rsz : ADDR_W'(1) + w_woff;
  assign o_result_base = w_s ? (i_rsz << 1) + i_rsz : w_roff;
  assign o_rows        = i_rows;
  assign o_inner       = w_s ? i_cols : i_inner;
  assign o_cols        = w_s ? i_rows : i_cols;
endmodule

// File: rtl/attn_phase_sequencer.sv
// attn_phase_sequencer: fetches SRAM dimension headers and runs the MAC through Q, K, V (plus S when ATTN_SCORE_PHASE_EN)
module attn_phase_sequencer
  import attn_seq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dut_valid,
  output logic              dut_ready,
  output logic              hdr_own,
  output logic [ADDR_W-1:0] hdr_input_read_address,
  output logic [ADDR_W-1:0] hdr_weight_read_address,
  input  logic [DATA_W-1:0] tb__dut__sram_input_read_data,
  input  logic [DATA_W-1:0] tb__dut__sram_weight_read_data,
  output logic              mac_valid,
  input  logic              mac_ready,
  output logic              mac_src_sel,
  output logic [ADDR_W-1:0] mac_opa_base,
  output logic [ADDR_W-1:0] mac_opb_base,
  output logic [ADDR_W-1:0] mac_result_base,
  output logic [DIM_W-1:0]  mac_rows,
  output logic [DIM_W-1:0]  mac_inner,
  output logic [DIM_W-1:0]  mac_cols,
  output logic              err_zero_dim
);
  logic [2:0]        r_state, w_next;
  phase_t            r_phase, w_phase;
  logic [DIM_W-1:0]  r_rows, r_inner, r_cols;
  logic [DIM_W-1:0]  w_hrows, w_hinner, w_hcols;
  logic [ADDR_W-1:0] r_wsz, r_rsz, w_wsz, w_rsz, w_gwsz, w_grsz;
  logic              w_zero, w_last, w_load, w_unused;
  logic              w_src;
  logic [ADDR_W-1:0] w_opa, w_opb, w_res;
  logic [DIM_W-1:0]  w_rows, w_inner, w_cols;
  assign w_hrows  = tb__dut__sram_input_read_data[HDR_ROWS_LSB +: DIM_W];
  assign w_hinner = tb__dut__sram_input_read_data[HDR_INNER_LSB +: DIM_W];
  assign w_hcols  = tb__dut__sram_weight_read_data[HDR_COLS_LSB +: DIM_W];
  assign w_unused = ^tb__dut__sram_weight_read_data[DATA_W-1:DIM_W];
  assign w_zero   = ~|w_hrows | ~|w_hinner | ~|w_hcols;
  assign w_wsz    = ADDR_W'(r_inner) * ADDR_W'(r_cols);
  assign w_rsz    = ADDR_W'(r_rows) * ADDR_W'(r_cols);
  assign w_last   = r_phase == PH_LAST;
  // config for the next job is latched on entry to START: from CALC (phase Q) or from DONE (next phase)
  assign w_phase  = r_state == ST_CALC ? PH_Q : phase_t'(r_phase + 2'd1);
  assign w_gwsz   = r_state == ST_CALC ? w_wsz : r_wsz;
  assign w_grsz   = r_state == ST_CALC ? w_rsz : r_rsz;
  assign w_load   = r_state == ST_CALC | (r_state == ST_DONE & mac_ready & ~w_last);
  assign hdr_own  = r_state == ST_FETCH | r_state == ST_FETCH_WAIT;
  assign hdr_input_read_address  = '0;
  assign hdr_weight_read_address = '0;
  assign mac_valid = reset_n & r_state == ST_START & mac_ready;
  phase_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_gen (
    .i_phase      (w_phase),
    .i_wsz        (w_gwsz),
    .i_rsz        (w_grsz),
    .i_rows       (r_rows),
    .i_inner      (r_inner),
    .i_cols       (r_cols),
    .o_src_sel    (w_src),
    .o_opa_base   (w_opa),
    .o_opb_base   (w_opb),
    .o_result_base(w_res),
    .o_rows       (w_rows),
    .o_inner      (w_inner),
    .o_cols       (w_cols)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       w_next = dut_valid ? ST_FETCH : ST_IDLE;
      ST_FETCH:      w_next = ST_FETCH_WAIT;
      ST_FETCH_WAIT: w_next = w_zero ? ST_IDLE : ST_CALC;
      ST_CALC:       w_next = ST_START;
      ST_START:      w_next = mac_ready ? ST_ACK : ST_START;
      ST_ACK:        w_next = mac_ready ? ST_ACK : ST_DONE;
      ST_DONE:       w_next = mac_ready ? (w_last ? ST_IDLE : ST_START) : ST_DONE;
      default:       w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_phase         <= PH_Q;
      r_rows          <= '0;
      r_inner         <= '0;
      r_cols          <= '0;
      r_wsz           <= '0;
      r_rsz           <= '0;
      dut_ready       <= 1'b0;
      err_zero_dim    <= 1'b0;
      mac_src_sel     <= 1'b0;
      mac_opa_base    <= '0;
      mac_opb_base    <= '0;
      mac_result_base <= '0;
      mac_rows        <= '0;
      mac_inner       <= '0;
      mac_cols        <= '0;
    end else begin
      r_state   <= w_next;
      dut_ready <= w_next == ST_IDLE;
      if (r_state == ST_IDLE && dut_valid) err_zero_dim <= 1'b0;
      if (r_state == ST_FETCH_WAIT) begin
        r_rows       <= w_hrows;
        r_inner      <= w_hinner;
        r_cols       <= w_hcols;
        err_zero_dim <= w_zero;
      end
      if (r_state == ST_CALC) begin
        r_wsz <= w_wsz;
        r_rsz <= w_rsz;
      end
      if (w_load) begin
        r_phase         <= w_phase;
        mac_src_sel     <= w_src;
        mac_opa_base    <= w_opa;
        mac_opb_base    <= w_opb;
        mac_result_base <= w_res;
        mac_rows        <= w_rows;
        mac_inner       <= w_inner;
        mac_cols        <= w_cols;
      end
    end
  end
endmodule

// File: tb/tb_attn_phase_sequencer.sv
// tb_attn_phase_sequencer: directed bench with header SRAM and busy-MAC models (job count follows ATTN_SCORE_PHASE_EN)
module tb_attn_phase_sequencer;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 16;
`ifdef ATTN_SCORE_PHASE_EN
  localparam int NJOB = 4;
`else
  localparam int NJOB = 3;
`endif
  localparam int READY_CYC = 4 + 12 * NJOB;
  localparam int LAST_RES  = 32 * (NJOB - 1);
  logic clk = 1'b0, reset_n = 1'b0, dut_valid = 1'b0, mac_hold = 1'b0;
  logic mac_ready, dut_ready, hdr_own, mac_valid, mac_src_sel, err_zero_dim;
  logic [ADDR_W-1:0] hdr_input_read_address, hdr_weight_read_address;
  logic [ADDR_W-1:0] mac_opa_base, mac_opb_base, mac_result_base;
  logic [DIM_W-1:0]  mac_rows, mac_inner, mac_cols;
  logic [DATA_W-1:0] hdr_in = '0, hdr_w = '0;
  logic [DATA_W-1:0] in_rd = 32'hDEADBEEF, w_rd = 32'hDEADBEEF;
  int mac_cnt = 0, n_jobs = 0, n_cmp = 0, n_err = 0;
  logic [ADDR_W-1:0] j_opa[8], j_opb[8], j_res[8];
  logic              j_src[8];
  logic [DIM_W-1:0]  j_rows[8], j_inner[8], j_cols[8];

  attn_phase_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .reset_n(reset_n), .dut_valid(dut_valid), .dut_ready(dut_ready),
    .hdr_own(hdr_own), .hdr_input_read_address(hdr_input_read_address),
    .hdr_weight_read_address(hdr_weight_read_address),
    .tb__dut__sram_input_read_data(in_rd), .tb__dut__sram_weight_read_data(w_rd),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_src_sel(mac_src_sel),
    .mac_opa_base(mac_opa_base), .mac_opb_base(mac_opb_base), .mac_result_base(mac_result_base),
    .mac_rows(mac_rows), .mac_inner(mac_inner), .mac_cols(mac_cols), .err_zero_dim(err_zero_dim)
  );

  always #5 clk = ~clk;
  assign mac_ready = (mac_cnt == 0) & ~mac_hold;

  // header SRAM answers address 0 one cycle later; MAC is busy 10 cycles after each start
  always @(posedge clk) begin
    in_rd <= (hdr_own && hdr_input_read_address == '0) ? hdr_in : 32'hDEADBEEF;
    w_rd  <= (hdr_own && hdr_weight_read_address == '0) ? hdr_w : 32'hDEADBEEF;
    if (mac_valid) mac_cnt <= 10;
    else if (mac_cnt > 0) mac_cnt <= mac_cnt - 1;
    if (mac_valid) begin
      if (n_jobs < 8) begin
        j_opa[n_jobs]   <= mac_opa_base;
        j_opb[n_jobs]   <= mac_opb_base;
        j_res[n_jobs]   <= mac_result_base;
        j_src[n_jobs]   <= mac_src_sel;
        j_rows[n_jobs]  <= mac_rows;
        j_inner[n_jobs] <= mac_inner;
        j_cols[n_jobs]  <= mac_cols;
      end
      n_jobs <= n_jobs + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 200 && !dut_ready; i++) tick(1);
    check(tag, 32'(dut_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, base, own;
    tick(2);
    check("rst_ready", 32'(dut_ready), 32'd0);
    check("rst_mac_valid", 32'(mac_valid), 32'd0);
    check("rst_hdr_own", 32'(hdr_own), 32'd0);
    check("rst_err", 32'(err_zero_dim), 32'd0);
    check("rst_opb", 32'(mac_opb_base), 32'd0);
    reset_n = 1'b1;
    tick(1);
    check("ready_after_rst", 32'(dut_ready), 32'd1);

    // full job: rows=4 inner=8 cols=8 -> wsz=64, rsz=32
    hdr_in = {16'd4, 16'd8};
    hdr_w  = 32'hABCD_0008;
    dut_valid = 1'b1;
    tick(1);
    dut_valid = 1'b0;
    check("fetch_own", 32'(hdr_own), 32'd1);
    check("fetch_busy", 32'(dut_ready), 32'd0);
    tick(3);
    check("q_valid_c4", 32'(mac_valid), 32'd1);
    check("q_src", 32'(mac_src_sel), 32'd0);
    check("q_opa", 32'(mac_opa_base), 32'd1);
    check("q_opb", 32'(mac_opb_base), 32'd1);
    check("q_res", 32'(mac_result_base), 32'd0);
    check("q_rows", 32'(mac_rows), 32'd4);
    check("q_inner", 32'(mac_inner), 32'd8);
    check("q_cols", 32'(mac_cols), 32'd8);
    t = 4;
    while (!dut_ready && t < 200) begin
      tick(1);
      t++;
    end
    check("ready_cycle", 32'(t), 32'(READY_CYC));
    check("job_count", 32'(n_jobs), 32'(NJOB));
    check("k_opb", 32'(j_opb[1]), 32'd65);
    check("k_res", 32'(j_res[1]), 32'd32);
    check("k_src", 32'(j_src[1]), 32'd0);
    check("v_opb", 32'(j_opb[2]), 32'd129);
    check("v_res", 32'(j_res[2]), 32'd64);
    check("v_opa", 32'(j_opa[2]), 32'd1);
    check("v_cols", 32'(j_cols[2]), 32'd8);
`ifdef ATTN_SCORE_PHASE_EN
    check("s_src", 32'(j_src[3]), 32'd1);
    check("s_opa", 32'(j_opa[3]), 32'd0);
    check("s_opb", 32'(j_opb[3]), 32'd32);
    check("s_res", 32'(j_res[3]), 32'd96);
    check("s_rows", 32'(j_rows[3]), 32'd4);
    check("s_inner", 32'(j_inner[3]), 32'd8);
    check("s_cols", 32'(j_cols[3]), 32'd4);
`endif
    check("idle_hold_res", 32'(mac_result_base), 32'(LAST_RES));
    check("job_err_clear", 32'(err_zero_dim), 32'd0);

    // zero inner dimension aborts without a MAC job
    hdr_in = {16'd4, 16'd0};
    base = n_jobs;
    dut_valid = 1'b1;
    tick(1);
    dut_valid = 1'b0;
    tick(2);
    check("zero_err", 32'(err_zero_dim), 32'd1);
    check("zero_ready", 32'(dut_ready), 32'd1);
    tick(3);
    check("zero_nojob", 32'(n_jobs), 32'(base));

    // MAC not ready on entering START: pulse waits for mac_ready
    hdr_in = {16'd4, 16'd8};
    mac_hold = 1'b1;
    dut_valid = 1'b1;
    tick(1);
    dut_valid = 1'b0;
    check("err_cleared", 32'(err_zero_dim), 32'd0);
    tick(3);
    check("stall_c4", 32'(mac_valid), 32'd0);
    tick(4);
    check("stall_c8", 32'(mac_valid), 32'd0);
    check("stall_nojob", 32'(n_jobs), 32'(base));
    tick(1);
    mac_hold = 1'b0;
    #1;
    check("stall_release", 32'(mac_valid), 32'd1);
    tick(1);
    check("stall_single", 32'(mac_valid), 32'd0);
    check("stall_one_job", 32'(n_jobs), 32'(base + 1));
    wait_ready("stall_done");
    check("stall_jobs", 32'(n_jobs), 32'(base + NJOB));

    // reset during phase K ACK
    dut_valid = 1'b1;
    tick(1);
    dut_valid = 1'b0;
    tick(15);
    check("k_valid_c16", 32'(mac_valid), 32'd1);
    check("k_opb_live", 32'(mac_opb_base), 32'd65);
    tick(1);
    reset_n = 1'b0;
    tick(1);
    check("abort_valid", 32'(mac_valid), 32'd0);
    check("abort_ready", 32'(dut_ready), 32'd0);
    check("abort_opb", 32'(mac_opb_base), 32'd0);
    reset_n = 1'b1;
    tick(1);
    check("abort_release_ready", 32'(dut_ready), 32'd1);

    // reset while START is pulsing must drop mac_valid at once
    for (int i = 0; i < 50 && !mac_ready; i++) tick(1);
    check("mac_idle", 32'(mac_ready), 32'd1);
    base = n_jobs;
    dut_valid = 1'b1;
    tick(1);
    dut_valid = 1'b0;
    tick(3);
    check("start_valid", 32'(mac_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_gates_valid", 32'(mac_valid), 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("rst_start_ready", 32'(dut_ready), 32'd1);
    check("rst_start_nojob", 32'(n_jobs), 32'(base));

    // dut_valid held high: no re-accept until IDLE
    base = n_jobs;
    own = 0;
    dut_valid = 1'b1;
    tick(1);
    t = 1;
    while (!dut_ready && t < 200) begin
      own += 32'(hdr_own);
      tick(1);
      t++;
    end
    check("held_ready_cycle", 32'(t), 32'(READY_CYC));
    check("held_fetch_cycles", 32'(own), 32'd2);
    check("held_jobs", 32'(n_jobs), 32'(base + NJOB));
    tick(1);
    check("held_reaccept", 32'(hdr_own), 32'd1);
    dut_valid = 1'b0;
    wait_ready("held_second_done");
    check("held_jobs2", 32'(n_jobs), 32'(base + 2 * NJOB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/attn_phase_sequencer.md
Name: attn_phase_sequencer

Overview:
- Top-level controller that runs the shared MAC datapath through consecutive matrix-multiply phases: Q, K, V and optionally S = Q*K^T.
- Handles the dut_valid/dut_ready handshake with the bench.
- Fetches the dimension headers from the input and weight SRAMs.
- Computes per-phase weight/result base addresses and matrix dimensions, then issues one MAC job per phase.
- Sits between the top-level wrapper and the MAC; replaces the ad-hoc two-phase FSM in the wrapper.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 32, SRAM data width.
- DIM_W, 16, width of each matrix dimension field.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- dut_valid  in  1  job request from bench
- dut_ready  out  1  sequencer idle, request accepted when high
- hdr_own  out  1  sequencer drives SRAM read addresses (header fetch); top muxes on this
- hdr_input_read_address  out  ADDR_W  input SRAM read address
- hdr_weight_read_address  out  ADDR_W  weight SRAM read address
- tb__dut__sram_input_read_data  in  DATA_W  input SRAM data
- tb__dut__sram_weight_read_data  in  DATA_W  weight SRAM data
- mac_valid  out  1  one-cycle job start pulse
- mac_ready  in  1  MAC idle (level)
- mac_src_sel  out  1  0: input x weight; 1: result x result-transposed
- mac_opa_base  out  ADDR_W  operand A base address
- mac_opb_base  out  ADDR_W  operand B base address
- mac_result_base  out  ADDR_W  result write base address
- mac_rows, mac_inner, mac_cols  out  DIM_W each  job dimensions
- err_zero_dim  out  1  sticky: last request had a zero dimension

Behaviour:
- Reset, synchronous, sampled at clk edge while reset_n=0:
  - state IDLE; all outputs 0, including dut_ready.
  - dut_ready rises the first cycle after reset_n deasserts.
  - Reset mid-job aborts immediately. mac_valid is never asserted in the reset cycle.
- Headers:
  - Input SRAM word 0 = {rows[31:16], inner[15:0]}.
  - Weight SRAM word 0 bits[15:0] = cols.
  - SRAM read latency is 1 cycle.
- States:
  - IDLE: dut_ready=1; dut_valid=1 -> FETCH, and err_zero_dim clears. dut_valid outside IDLE is ignored.
  - FETCH: hdr_own=1, both addresses 0 -> FETCH_WAIT.
  - FETCH_WAIT: hdr_own=1; capture rows/inner/cols at end of cycle. If any dimension is 0 -> set err_zero_dim, go to IDLE. Else -> CALC.
  - CALC: register wsz = inner*cols and rsz = rows*cols (truncated to ADDR_W); phase=Q -> START.
  - START: hold config. When mac_ready=1, pulse mac_valid for 1 cycle -> ACK.
  - ACK: wait for mac_ready=0 -> DONE.
  - DONE: wait for mac_ready=1. Then, if the phase is the last one -> IDLE; else advance phase -> START.
- Earliest timing: dut_valid sampled at edge 0 -> mac_valid high in cycle 4.
- Phase config (weight base starts at 1, skipping the header):
  - Q: src_sel=0, opa_base=1, opb_base=1, result_base=0.
  - K: src_sel=0, opa_base=1, opb_base=1+wsz, result_base=rsz.
  - V: src_sel=0, opa_base=1, opb_base=1+2*wsz, result_base=2*rsz.
  - Q, K, V all use dims rows/inner/cols.
  - opa_base for src_sel=0 phases is the input base, i.e. row 1 after the header.
- mac_* outputs are registered and stable from START through DONE. They hold their last values in IDLE.
- Arithmetic is unsigned, with products truncated to ADDR_W; no overflow detection.
- If mac_ready is already low in START, the sequencer waits. It never pulses mac_valid while mac_ready=0.

Optional Feature:
- Macro: ATTN_SCORE_PHASE_EN.
- Defined: a fourth phase S runs after V, and S is the last phase.
  - src_sel=1, opa_base=0 (Q), opb_base=rsz (K), result_base=3*rsz.
  - dims rows=rows, inner=cols, cols=rows.
- Undefined: V is the last phase and the S logic is absent.

Decomposition:
- Package attn_seq_pkg:
  - state enum: IDLE, FETCH, FETCH_WAIT, CALC, START, ACK, DONE.
  - phase enum: Q, K, V, S.
  - SRC_IN_W / SRC_RES_RES constants.
  - header field bit positions.
- Sub-module phase_addr_gen: combinational. Maps (phase, wsz, rsz, dims) to bases, dims and src_sel; registered in the parent.

Test Plan:
- Headers rows=4, inner=8, cols=8; MAC model drops ready 1 cycle after valid and is busy 10 cycles:
  - mac_valid exactly 3 times.
  - (opb_base, result_base) = (1,0), (65,32), (129,64).
  - dut_ready returns 1 the cycle after the third DONE.
- Same headers with ATTN_SCORE_PHASE_EN: fourth job with src_sel=1, opa=0, opb=32, result=96, dims 4/8/4.
- Header inner=0 -> no mac_valid; err_zero_dim=1; dut_ready=1 within 3 cycles. Next dut_valid clears err_zero_dim.
- mac_ready held low 5 cycles on entering START -> mac_valid delayed until the mac_ready=1 edge; single pulse only.
- reset_n=0 during phase K ACK -> the next cycle shows IDLE with mac_valid=0 and dut_ready=0; dut_ready=1 one cycle after release.
- dut_valid held high through a whole job -> the second job starts only after return to IDLE; no request is accepted mid-job.
